// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters with round-robin arbitration.
// Latency: accept at T, ALU evaluates at T+1, response valid from T+2 (3 cycles minimum).
// Backpressure: one op in flight; req_ready is low outside IDLE and RESP holds until the owner consumes.
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         req_valid_0,
  input  logic         req_valid_1,
  output logic         req_ready_0,
  output logic         req_ready_1,
  input  logic [W-1:0] req_a_0,
  input  logic [W-1:0] req_a_1,
  input  logic [W-1:0] req_b_0,
  input  logic [W-1:0] req_b_1,
  input  logic [2:0]   req_op_0,
  input  logic [2:0]   req_op_1,
  output logic         rsp_valid_0,
  output logic         rsp_valid_1,
  input  logic         rsp_ready_0,
  input  logic         rsp_ready_1,
  output logic [W-1:0] rsp_c,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_op,
  input  logic [W-1:0] alu_c,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_q;
  logic           owner_q;      // port that owns the in-flight op
  logic           last_q;       // port that won the most recent grant
  logic [W-1:0]   alu_a_q;
  logic [W-1:0]   alu_b_q;
  logic [2:0]     alu_op_q;
  logic [W-1:0]   rsp_c_q;
  logic           rsp_valid_0_q;
  logic           rsp_valid_1_q;
  logic           busy_q;

  logic           grant_0;
  logic           grant_1;
  logic           accept_0;
  logic           accept_1;
  logic           rsp_ready_owner;

  // Round-robin grant: a lone requester wins, a tie goes to the port that did not win last
  always_comb begin
    grant_0 = req_valid_0 && (!req_valid_1 || last_q);
    grant_1 = req_valid_1 && (!req_valid_0 || !last_q);
  end

  assign req_ready_0     = (state_q == IDLE) && grant_0;
  assign req_ready_1     = (state_q == IDLE) && grant_1;
  assign accept_0        = req_valid_0 && req_ready_0;
  assign accept_1        = req_valid_1 && req_ready_1;
  // The non-owner's rsp_ready has no effect on completion
  assign rsp_ready_owner = owner_q ? rsp_ready_1 : rsp_ready_0;

  // Single FSM: load operands on accept, capture the ALU result in EXEC, hold it in RESP until consumed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_q       <= 1'b0;
      last_q        <= 1'b1;
      alu_a_q       <= '0;
      alu_b_q       <= '0;
      alu_op_q      <= 3'b000;
      rsp_c_q       <= '0;
      rsp_valid_0_q <= 1'b0;
      rsp_valid_1_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_0 || accept_1) begin
            alu_a_q  <= accept_1 ? req_a_1  : req_a_0;
            alu_b_q  <= accept_1 ? req_b_1  : req_b_0;
            alu_op_q <= accept_1 ? req_op_1 : req_op_0;
            owner_q  <= accept_1;
            last_q   <= accept_1;
            busy_q   <= 1'b1;
            state_q  <= EXEC;
          end
        end
        EXEC: begin
          rsp_c_q       <= alu_c;
          rsp_valid_0_q <= !owner_q;
          rsp_valid_1_q <= owner_q;
          state_q       <= RESP;
        end
        RESP: begin
          if (rsp_ready_owner) begin
            rsp_valid_0_q <= 1'b0;
            rsp_valid_1_q <= 1'b0;
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_op      = alu_op_q;
  assign rsp_c       = rsp_c_q;
  assign rsp_valid_0 = rsp_valid_0_q;
  assign rsp_valid_1 = rsp_valid_1_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized transactions against a transaction-level model.
// The shared ALU is modelled behaviourally and fed from the DUT's registered ALU operands.
// Expected grants come from a round-robin "last winner" variable, expected results from the opcode table.
module tb_alu_arbiter;

  logic        clk;
  logic        reset;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [31:0] req_a_0, req_a_1, req_b_0, req_b_1;
  logic [2:0]  req_op_0, req_op_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [31:0] rsp_c, alu_a, alu_b, alu_c;
  logic [2:0]  alu_op;
  logic        busy;

  int total = 0;
  int bad   = 0;
  int m_last;   // model: port that won the most recent grant

  alu_arbiter #(.W(32)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_a_0(req_a_0), .req_a_1(req_a_1),
    .req_b_0(req_b_0), .req_b_1(req_b_1),
    .req_op_0(req_op_0), .req_op_1(req_op_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1),
    .rsp_c(rsp_c), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_c(alu_c), .busy(busy)
  );

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a - b;
      3'b010:  return a & b;
      3'b011:  return a | b;
      3'b100:  return a >> b;
      3'b101:  return $unsigned($signed(a) >>> b);
      default: return 32'h0;
    endcase
  endfunction

  assign alu_c = alu_f(alu_a, alu_b, alu_op);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One full transaction: present request(s), check grant, EXEC, RESP with bp stalled cycles, handshake.
  task automatic xact(input bit v0, input bit v1,
                      input logic [31:0] a0, input logic [31:0] b0, input logic [2:0] op0,
                      input logic [31:0] a1, input logic [31:0] b1, input logic [2:0] op1,
                      input int bp, output int win, output logic [31:0] res);
    int w;
    logic [31:0] ea, eb, er;
    logic [2:0]  eo;
    w  = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    eo = w ? op1 : op0;
    er = alu_f(ea, eb, eo);
    req_valid_0 = v0; req_valid_1 = v1;
    req_a_0 = a0; req_b_0 = b0; req_op_0 = op0;
    req_a_1 = a1; req_b_1 = b1; req_op_1 = op1;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    #1;
    chk("grant_rdy0", req_ready_0, w == 0);
    chk("grant_rdy1", req_ready_1, w == 1);
    chk("idle_busy", busy, 0);
    step;
    m_last = w;
    // Both ports clamour during the busy phase; the non-owner also asserts rsp_ready, which must be ignored
    req_valid_0 = 1'b1; req_valid_1 = 1'b1;
    if (w == 1) rsp_ready_0 = 1'b1; else rsp_ready_1 = 1'b1;
    #1;
    chk("exec_alu_a", alu_a, ea);
    chk("exec_alu_b", alu_b, eb);
    chk("exec_alu_op", alu_op, eo);
    chk("exec_busy", busy, 1);
    chk("exec_rsp_vld", {rsp_valid_1, rsp_valid_0}, 0);
    chk("exec_req_rdy", {req_ready_1, req_ready_0}, 0);
    step;
    for (int i = 0; i < bp; i++) begin
      #1;
      chk("bp_vld_owner", w ? rsp_valid_1 : rsp_valid_0, 1);
      chk("bp_vld_other", w ? rsp_valid_0 : rsp_valid_1, 0);
      chk("bp_rsp_c", rsp_c, er);
      chk("bp_req_rdy", {req_ready_1, req_ready_0}, 0);
      chk("bp_busy", busy, 1);
      step;
    end
    req_valid_0 = 1'b0; req_valid_1 = 1'b0;
    if (w == 1) rsp_ready_1 = 1'b1; else rsp_ready_0 = 1'b1;
    #1;
    chk("hs_vld_owner", w ? rsp_valid_1 : rsp_valid_0, 1);
    chk("hs_vld_other", w ? rsp_valid_0 : rsp_valid_1, 0);
    chk("hs_rsp_c", rsp_c, er);
    chk("hs_busy", busy, 1);
    res = rsp_c;
    step;
    chk("done_rsp_vld", {rsp_valid_1, rsp_valid_0}, 0);
    chk("done_busy", busy, 0);
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    win = w;
  endtask

  // Start an op on port 1 and reset it mid-flight (in EXEC, or in RESP when in_resp is set)
  task automatic reset_mid(input bit in_resp);
    int w;
    logic [31:0] r;
    req_valid_1 = 1'b1; req_a_1 = 32'd7; req_b_1 = 32'd9; req_op_1 = 3'b000;
    rsp_ready_0 = 1'b0; rsp_ready_1 = 1'b0;
    #1;
    chk("rst_req_rdy1", req_ready_1, 1);
    step;
    m_last = 1;
    req_valid_1 = 1'b0;
    if (in_resp) begin
      step;
      #1;
      chk("rst_pre_vld1", rsp_valid_1, 1);
    end
    #1;
    reset = 1'b1;
    #1;
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_op", alu_op, 0);
    chk("rst_rsp_c", rsp_c, 0);
    chk("rst_rsp_vld", {rsp_valid_1, rsp_valid_0}, 0);
    chk("rst_busy", busy, 0);
    #1;
    reset = 1'b0;
    m_last = 1;
    rsp_ready_0 = 1'b1; rsp_ready_1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      chk("rst_no_rsp", {rsp_valid_1, rsp_valid_0}, 0);
      chk("rst_idle", busy, 0);
    end
    xact(1, 1, 32'd1, 32'd2, 3'b000, 32'd3, 32'd4, 3'b000, 0, w, r);
    chk("rst_tie_win", w, 0);
    chk("rst_tie_res", r, 32'd3);
  endtask

  initial begin
    int w;
    logic [31:0] r;
    int exp_w;
    reset = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0;
    req_a_0 = 0; req_a_1 = 0; req_b_0 = 0; req_b_1 = 0;
    req_op_0 = 0; req_op_1 = 0;
    rsp_ready_0 = 0; rsp_ready_1 = 0;
    m_last = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_alu_a", alu_a, 0);
    chk("reset_alu_b", alu_b, 0);
    chk("reset_alu_op", alu_op, 0);
    chk("reset_rsp_c", rsp_c, 0);
    chk("reset_rsp_vld", {rsp_valid_1, rsp_valid_0}, 0);
    chk("reset_busy", busy, 0);
    chk("reset_req_rdy", {req_ready_1, req_ready_0}, 0);
    reset = 1'b0;
    step;

    // Single op from port 0: 5 + 3
    xact(1, 0, 32'd5, 32'd3, 3'b000, 32'd0, 32'd0, 3'b000, 0, w, r);
    chk("single_win", w, 0);
    chk("single_res", r, 32'd8);

    // Tie and fairness after a fresh reset
    #1; reset = 1'b1; #1; reset = 1'b0; m_last = 1;
    step;
    for (int i = 0; i < 4; i++) begin
      xact(1, 1, 32'd10, 32'd4, 3'b001, 32'h8000_0000, 32'd4, 3'b101, 0, w, r);
      chk("tie_order", w, i % 2);
      chk("tie_res", r, (i % 2) ? 32'hF800_0000 : 32'd6);
    end

    // Response backpressure on port 1 for 5 cycles
    xact(0, 1, 32'd0, 32'd0, 3'b000, 32'h0000_00F0, 32'd4, 3'b100, 5, w, r);
    chk("bp_win", w, 1);
    chk("bp_res", r, 32'h0F);

    // Reset during EXEC and during RESP
    reset_mid(1'b0);
    reset_mid(1'b1);

    // Logic opcodes and an undefined one
    xact(1, 0, 32'hFF00, 32'h0FF0, 3'b010, 32'd0, 32'd0, 3'b000, 0, w, r);
    chk("op_and", r, 32'h0F00);
    xact(1, 0, 32'hFF00, 32'h0FF0, 3'b011, 32'd0, 32'd0, 3'b000, 1, w, r);
    chk("op_or", r, 32'hFFF0);
    xact(1, 0, 32'hFF00, 32'h0FF0, 3'b111, 32'd0, 32'd0, 3'b000, 0, w, r);
    chk("op_111", r, 32'h0);

    // Randomized traffic checked against the model
    for (int n = 0; n < 40; n++) begin
      bit v0, v1;
      logic [31:0] a0, b0, a1, b1;
      logic [2:0] op0, op1;
      v0  = 1'($urandom_range(0, 1));
      v1  = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
      a0  = $urandom; a1 = $urandom;
      b0  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
      b1  = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 40);
      op0 = 3'($urandom_range(0, 7));
      op1 = 3'($urandom_range(0, 7));
      exp_w = (v0 && v1) ? ((m_last == 1) ? 0 : 1) : (v0 ? 0 : 1);
      xact(v0, v1, a0, b0, op0, a1, b1, op1, $urandom_range(0, 3), w, r);
      chk("rand_win", w, exp_w);
      chk("rand_res", r, exp_w ? alu_f(a1, b1, op1) : alu_f(a0, b0, op0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
